// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the RV32I instruction encoder/loader.
//  - 7-bit major opcodes (same values as the decoder side)
//  - bit positions inside the one-hot instruction-type vector
//  - loader FSM state type
package instr_encoder_loader_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // One-hot type vector layout: {lui,auipc,jalr,jal,branch,load,store,i_type,r_type}
  localparam int unsigned TYPE_W   = 9;
  localparam int unsigned T_R      = 0;
  localparam int unsigned T_I      = 1;
  localparam int unsigned T_STORE  = 2;
  localparam int unsigned T_LOAD   = 3;
  localparam int unsigned T_BRANCH = 4;
  localparam int unsigned T_JAL    = 5;
  localparam int unsigned T_JALR   = 6;
  localparam int unsigned T_AUIPC  = 7;
  localparam int unsigned T_LUI    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } load_state_e;

  // True when exactly one bit of the type vector is set.
  function automatic logic is_onehot(input logic [TYPE_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < TYPE_W; i++) begin
      cnt += int'(v[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/rv32i_instr_encoder.sv
// Purely combinational RV32I encoder: decoded fields -> 32-bit instruction word.
// Ports:
//  in_type   one-hot instruction type (layout in instr_encoder_loader_pkg)
//  rd/rs1/rs2, funct3, funct7, imm   decoded fields (imm is an unshifted byte offset / U-value)
//  word      encoded instruction (don't-care when onehot_ok is low)
//  onehot_ok exactly one type bit set
module rv32i_instr_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [TYPE_W-1:0] in_type,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic [31:0]       word,
  output logic              onehot_ok
);

  logic is_shift_imm;

  assign onehot_ok    = is_onehot(in_type);
  // SLLI/SRLI/SRAI: funct7 occupies the upper immediate bits, shamt is imm[4:0]
  assign is_shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    word = '0;
    if (in_type[T_R]) begin
      word = {funct7, rs2, rs1, funct3, rd, OP_REG};
    end else if (in_type[T_I]) begin
      if (is_shift_imm) begin
        word = {funct7, imm[4:0], rs1, funct3, rd, OP_IMM};
      end else begin
        word = {imm[11:0], rs1, funct3, rd, OP_IMM};
      end
    end else if (in_type[T_STORE]) begin
      word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
    end else if (in_type[T_LOAD]) begin
      word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
    end else if (in_type[T_BRANCH]) begin
      word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
    end else if (in_type[T_JAL]) begin
      word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    end else if (in_type[T_JALR]) begin
      word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
    end else if (in_type[T_AUIPC]) begin
      word = {imm[31:12], rd, OP_AUIPC};
    end else if (in_type[T_LUI]) begin
      word = {imm[31:12], rd, OP_LUI};
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test loader: encodes RV32I field bundles and streams the words into IMEM
// at consecutive word addresses starting at BASE_ADDR.
// Ports:
//  clk, rst_n            clock / async active-low reset
//  start                 begin a session (honoured in IDLE/DONE/ERROR)
//  in_valid/in_ready     field-bundle handshake (ready only in LOAD)
//  in_type..in_imm       decoded fields, in_last marks the final word
//  mem_we/addr/wdata     IMEM write request, held until mem_ack
//  mem_ack               IMEM write accept
//  busy/done/err         status levels
//  words_written         acknowledged writes this session
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  load_state_e       state_q, state_d;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              last_q;

  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              start_fire;
  logic              accept;
  logic              ack_fire;

  rv32i_instr_encoder u_enc (
    .in_type   (in_type),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .funct7    (in_funct7),
    .imm       (in_imm),
    .word      (enc_word),
    .onehot_ok (enc_ok)
  );

  always_comb begin
    state_d    = state_q;
    start_fire = 1'b0;
    accept     = 1'b0;
    ack_fire   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          start_fire = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (enc_ok) begin
            accept  = 1'b1;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          ack_fire = 1'b1;
          if (last_q) begin
            state_d = ST_DONE;
          end else if (addr_q == ADDR_MAX) begin
            // address space exhausted before the last word: no wrap
            state_d = ST_ERROR;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      addr_q  <= BASE;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      if (start_fire) begin
        addr_q  <= BASE;
        count_q <= '0;
      end
      if (accept) begin
        word_q <= enc_word;
        last_q <= in_last;
      end
      if (ack_fire) begin
        count_q <= count_q + CNT_ONE;
        if (!last_q && (addr_q != ADDR_MAX)) begin
          addr_q <= addr_q + ADDR_ONE;
        end
      end
    end
  end

  // mem_we is exactly "in WRITE": it rises the cycle after accept and
  // falls asynchronously with reset because the state register does.
  assign mem_we        = (state_q == ST_WRITE);
  assign in_ready      = (state_q == ST_LOAD);
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign done          = (state_q == ST_DONE);
  assign err           = (state_q == ST_ERROR);
  assign mem_addr      = addr_q;
  assign mem_wdata     = word_q;
  assign words_written = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // shared field bus
  logic [8:0]  in_type = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;

  // instance A: ADDR_W=8, BASE_ADDR=0
  logic        a_start = 0, a_in_valid = 0, a_in_last = 0, a_mem_ack = 0;
  logic        a_in_ready, a_mem_we, a_busy, a_done, a_err;
  logic [7:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [8:0]  a_ww;

  // instance B: ADDR_W=2 for overflow behaviour
  logic        b_start = 0, b_in_valid = 0, b_in_last = 0, b_mem_ack = 0;
  logic        b_in_ready, b_mem_we, b_busy, b_done, b_err;
  logic [1:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [2:0]  b_ww;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_addr = 0;
  int unsigned exp_ww = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(a_in_last),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_ack(a_mem_ack),
    .busy(a_busy), .done(a_done), .err(a_err), .words_written(a_ww)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(b_in_last),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack),
    .busy(b_busy), .done(b_done), .err(b_err), .words_written(b_ww)
  );

  // Reference encoder built from the ISA bit-field rules with shifts and masks.
  // Type index: 0 R, 1 I, 2 store, 3 load, 4 branch, 5 jal, 6 jalr, 7 auipc, 8 lui
  function automatic bit [31:0] ref_encode(input int unsigned t, input bit [31:0] rd,
      input bit [31:0] rs1, input bit [31:0] rs2, input bit [31:0] f3,
      input bit [31:0] f7, input bit [31:0] imm);
    bit [31:0] regs;
    regs = (rs2 << 20) | (rs1 << 15) | (f3 << 12);
    case (t)
      0: return (f7 << 25) | regs | (rd << 7) | 32'h33;
      1: if (f3 == 1 || f3 == 5)
           return (f7 << 25) | ((imm & 32'h1f) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         else
           return ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      2: return (((imm >> 5) & 32'h7f) << 25) | regs | ((imm & 32'h1f) << 7) | 32'h23;
      3: return ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      4: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | regs
              | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
      5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
              | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | (rd << 7) | 32'h6f;
      6: return ((imm & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      7: return (imm & 32'hfffff000) | (rd << 7) | 32'h17;
      default: return (imm & 32'hfffff000) | (rd << 7) | 32'h37;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int unsigned t, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_type   = 9'(1 << t);
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic start_a();
    a_start = 1; step(); a_start = 0;
    exp_addr = 0; exp_ww = 0;
  endtask

  // One word through instance A: accept, hold ack low dly cycles, then ack.
  task automatic send_a(input int unsigned t, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      input bit lst, input int unsigned dly, input bit has_lit, input logic [31:0] lit);
    bit [31:0] exp_w;
    int unsigned guard;
    exp_w = ref_encode(t, 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), imm);
    guard = 0;
    while (!a_in_ready && guard < 20) begin step(); guard++; end
    chk("in_ready_before_accept", a_in_ready, 1);
    set_fields(t, rd, rs1, rs2, f3, f7, imm);
    a_in_last = lst; a_in_valid = 1;
    step();
    a_in_valid = 0; a_in_last = 0;
    chk("mem_we_after_accept", a_mem_we, 1);
    chk("mem_addr", a_mem_addr, exp_addr);
    chk("mem_wdata", a_mem_wdata, exp_w);
    if (has_lit) chk("mem_wdata_literal", a_mem_wdata, lit);
    chk("in_ready_in_write", a_in_ready, 0);
    for (int unsigned i = 0; i < dly; i++) begin
      step();
      chk("hold_mem_we", a_mem_we, 1);
      chk("hold_mem_addr", a_mem_addr, exp_addr);
      chk("hold_mem_wdata", a_mem_wdata, exp_w);
      chk("hold_in_ready", a_in_ready, 0);
      chk("hold_words", a_ww, exp_ww);
    end
    a_mem_ack = 1;
    step();
    a_mem_ack = 0;
    exp_ww++;
    chk("mem_we_after_ack", a_mem_we, 0);
    chk("words_written", a_ww, exp_ww);
    if (lst) begin
      chk("done_after_last", a_done, 1);
      chk("busy_after_last", a_busy, 0);
      chk("addr_after_last", a_mem_addr, exp_addr);
    end else begin
      exp_addr++;
      chk("addr_incr", a_mem_addr, exp_addr);
      chk("in_ready_after_ack", a_in_ready, 1);
    end
  endtask

  // One word through instance B, acked on the first write cycle.
  task automatic send_b(input int unsigned t, input bit lst, input int unsigned idx);
    bit [31:0] exp_w;
    set_fields(t, 5'(idx + 1), 5'(idx), 5'(idx + 2), 3'(idx), 7'(idx), 32'(idx * 4));
    exp_w = ref_encode(t, 32'(idx + 1), 32'(idx), 32'(idx + 2), 32'(idx & 7), 32'(idx), 32'(idx * 4));
    chk("b_in_ready", b_in_ready, 1);
    b_in_last = lst; b_in_valid = 1;
    step();
    b_in_valid = 0; b_in_last = 0;
    chk("b_mem_we", b_mem_we, 1);
    chk("b_mem_addr", b_mem_addr, idx);
    chk("b_mem_wdata", b_mem_wdata, exp_w);
    b_mem_ack = 1;
    step();
    b_mem_ack = 0;
    chk("b_words", b_ww, idx + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // reset
    step(); step();
    chk("rst_mem_we", a_mem_we, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_mem_wdata", a_mem_wdata, 0);
    chk("rst_words", a_ww, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_in_ready", a_in_ready, 0);
    rst_n = 1;
    step();
    // in_valid outside LOAD is ignored
    set_fields(1, 1, 0, 0, 0, 0, 5);
    a_in_valid = 1; step(); a_in_valid = 0;
    chk("idle_ignores_valid", a_mem_we, 0);

    // directed words
    start_a();
    chk("start_busy", a_busy, 1);
    chk("start_in_ready", a_in_ready, 1);
    send_a(1, 1, 0, 0, 3'b000, 0, 32'd5, 0, 0, 1, 32'h00500093);
    send_a(0, 3, 1, 2, 3'b000, 0, 32'd0, 0, 1, 1, 32'h002081B3);
    send_a(2, 0, 1, 2, 3'b010, 0, 32'd8, 0, 0, 1, 32'h0020A423);
    send_a(4, 0, 1, 2, 3'b000, 0, 32'd16, 0, 5, 1, 32'h00208863);
    // start is ignored while busy
    a_start = 1;
    send_a(5, 1, 0, 0, 3'b000, 0, 32'd8, 0, 2, 1, 32'h008000EF);
    a_start = 0;
    send_a(8, 5, 0, 0, 3'b000, 0, 32'h12345000, 1, 0, 1, 32'h123452B7);

    // randomized session
    start_a();
    for (int unsigned n = 0; n < 30; n++) begin
      send_a($urandom_range(8, 0), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
             7'($urandom), $urandom, (n == 29), $urandom_range(3, 0), 0, '0);
    end

    // invalid one-hot type -> ERROR, nothing written
    start_a();
    chk("restart_done_clear", a_done, 0);
    in_type = 9'b000000011;
    a_in_valid = 1; step(); a_in_valid = 0;
    chk("bad_type_mem_we", a_mem_we, 0);
    chk("bad_type_err", a_err, 1);
    chk("bad_type_busy", a_busy, 0);
    chk("bad_type_words", a_ww, 0);
    step();
    chk("bad_type_no_write", a_mem_we, 0);
    in_type = 9'b000000000;
    start_a();
    chk("err_restart_err", a_err, 0);
    chk("err_restart_addr", a_mem_addr, 0);
    chk("err_restart_ready", a_in_ready, 1);
    send_a(6, 2, 3, 0, 3'b111, 0, 32'h00000abc, 0, 0, 0, '0);

    // overflow at ADDR_W=2: four words without last -> ERROR after 4th ack
    b_start = 1; step(); b_start = 0;
    for (int unsigned i = 0; i < 4; i++) send_b(i % 9, 0, i);
    chk("b_overflow_err", b_err, 1);
    chk("b_overflow_words", b_ww, 4);
    chk("b_overflow_addr", b_mem_addr, 3);
    chk("b_overflow_ready", b_in_ready, 0);
    b_in_valid = 1; step(); b_in_valid = 0;
    chk("b_fifth_dropped", b_mem_we, 0);
    // last on the 4th -> DONE
    b_start = 1; step(); b_start = 0;
    chk("b_restart_addr", b_mem_addr, 0);
    for (int unsigned i = 0; i < 4; i++) send_b((i + 4) % 9, (i == 3), i);
    chk("b_done", b_done, 1);
    chk("b_done_err", b_err, 0);
    chk("b_done_words", b_ww, 4);
    chk("b_done_addr", b_mem_addr, 3);

    // reset in the middle of WRITE drops mem_we without a clock edge
    set_fields(0, 1, 2, 3, 0, 0, 0);
    a_in_valid = 1; step(); a_in_valid = 0;
    chk("pre_reset_mem_we", a_mem_we, 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_mem_we", a_mem_we, 0);
    chk("async_reset_words", a_ww, 0);
    chk("async_reset_busy", a_busy, 0);
    step();
    rst_n = 1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
